// File: rtl/weight_mem_pkg.sv
// Shared types and sizing for the loadable weight row memory.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package weight_mem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      READ = 2'd2
   } state_t;

   // Default geometry of the dense layer this loader normally serves
   localparam int DEF_DATA_WIDTH   = 32;
   localparam int DEF_INPUT_NODES  = 100;
   localparam int DEF_OUTPUT_NODES = 32;
   localparam int DEF_READ_LANES   = 8;
   localparam int DEF_ADDR_WIDTH   = 8;

   // Derived counts for the default geometry
   localparam int TOTAL  = DEF_INPUT_NODES * DEF_OUTPUT_NODES;
   localparam int BEATS  = DEF_OUTPUT_NODES / DEF_READ_LANES;
   localparam int PTR_W  = $clog2(TOTAL);
   localparam int BEAT_W = $clog2(BEATS);

   // Counter width that never collapses to zero bits for a count of one
   function automatic int width_of(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/weight_lane_bank.sv
// One lane of the weight store: 1 write port, 1 combinational read port.
// Latency: write lands on the clock edge; read data follows rd_addr in the same cycle.
// Backpressure: none; the caller sequences all accesses.
module weight_lane_bank
   import weight_mem_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int DEPTH      = TOTAL / DEF_READ_LANES,
   parameter int AW         = width_of(TOTAL / DEF_READ_LANES)
) (
   input  logic                  clk,
   input  logic                  wr_en,
   input  logic [AW-1:0]         wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic [AW-1:0]         rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);

   // Contents are deliberately not reset; they are only meaningful after a full load
   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // Store one accepted load word
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/weight_row_loader.sv
// Loadable INPUT_NODES x OUTPUT_NODES weight store returning whole rows over READ_LANES-wide beats.
// Latency: row valid BEATS cycles after accept; error response 1 cycle after accept; load_done 1 cycle after last word.
// Backpressure: load_ready only in LOAD, rd_ready only in IDLE; no output-side stall (rd_valid is a pulse).
module weight_row_loader
   import weight_mem_pkg::*;
#(
   parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
   parameter int INPUT_NODES  = DEF_INPUT_NODES,
   parameter int OUTPUT_NODES = DEF_OUTPUT_NODES,
   parameter int READ_LANES   = DEF_READ_LANES,
   parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               load_start,
   input  logic                               load_valid,
   input  logic [DATA_WIDTH-1:0]              load_data,
   output logic                               load_ready,
   output logic                               load_done,
   input  logic                               rd_req,
   input  logic [ADDR_WIDTH-1:0]              rd_addr,
   output logic                               rd_ready,
   output logic                               rd_valid,
   output logic                               rd_err,
   output logic [DATA_WIDTH*OUTPUT_NODES-1:0] rd_weights
);

   localparam int N_TOTAL = INPUT_NODES * OUTPUT_NODES;
   localparam int N_BEATS = OUTPUT_NODES / READ_LANES;
   localparam int DEPTH   = N_TOTAL / READ_LANES;
   localparam int P_W     = width_of(N_TOTAL);
   localparam int B_W     = width_of(N_BEATS);
   localparam int E_W     = width_of(DEPTH);
   localparam int L_W     = width_of(READ_LANES);
   localparam int ROW_W   = DATA_WIDTH * OUTPUT_NODES;

   state_t                state;
   logic                  loaded;
   logic                  load_fin;   // last word written; load_done follows one cycle later
   logic                  err_pend;   // rejected read; error response goes out next cycle
   logic [P_W-1:0]        wr_ptr;
   logic [B_W-1:0]        beat;
   logic [E_W-1:0]        rd_entry;
   logic [ROW_W-1:0]      row_buf;
   logic [ROW_W-1:0]      next_row;
   logic [DATA_WIDTH-1:0] lane_data [READ_LANES];

   logic                  wr_fire;
   logic [L_W-1:0]        wr_lane;
   logic [E_W-1:0]        wr_entry;
   logic                  addr_bad;

   assign wr_fire  = load_valid && load_ready;
   // Word k lives in lane k % READ_LANES at entry k / READ_LANES, so a row's
   // beat b sits at the same entry (row*BEATS + b) in every lane.
   assign wr_lane  = L_W'(32'(wr_ptr) % READ_LANES);
   assign wr_entry = E_W'(32'(wr_ptr) / READ_LANES);
   assign addr_bad = (int'(rd_addr) >= INPUT_NODES);

   for (genvar g = 0; g < READ_LANES; g++) begin : g_bank
      weight_lane_bank #(
         .DATA_WIDTH (DATA_WIDTH),
         .DEPTH      (DEPTH),
         .AW         (E_W)
      ) u_bank (
         .clk     (clk),
         .wr_en   (wr_fire && (wr_lane == L_W'(g))),
         .wr_addr (wr_entry),
         .wr_data (load_data),
         .rd_addr (rd_entry),
         .rd_data (lane_data[g])
      );
   end

   // Merge the current beat's lane words into the partially assembled row
   always_comb begin
      next_row = row_buf;
      for (int l = 0; l < READ_LANES; l++) begin
         next_row[(OUTPUT_NODES - 1 - (int'(beat) * READ_LANES + l)) * DATA_WIDTH +: DATA_WIDTH] = lane_data[l];
      end
   end

   // Control FSM with write pointer, beat counter, row assembly and registered handshakes
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         loaded     <= 1'b0;
         load_fin   <= 1'b0;
         err_pend   <= 1'b0;
         wr_ptr     <= '0;
         beat       <= '0;
         rd_entry   <= '0;
         row_buf    <= '0;
         load_ready <= 1'b0;
         load_done  <= 1'b0;
         rd_ready   <= 1'b0;
         rd_valid   <= 1'b0;
         rd_err     <= 1'b0;
         rd_weights <= '0;
      end else begin
         load_done <= load_fin;
         load_fin  <= 1'b0;
         rd_valid  <= err_pend;
         rd_err    <= err_pend;
         err_pend  <= 1'b0;
         if (err_pend) begin
            rd_weights <= '0;
         end
         case (state)
            IDLE: begin
               rd_ready   <= 1'b1;
               load_ready <= 1'b0;
               // A reload takes priority over a read offered in the same cycle
               if (load_start) begin
                  state      <= LOAD;
                  load_ready <= 1'b1;
                  rd_ready   <= 1'b0;
                  wr_ptr     <= '0;
                  loaded     <= 1'b0;
               end else if (rd_req && rd_ready) begin
                  if (addr_bad || !loaded) begin
                     err_pend <= 1'b1;
                  end else begin
                     state    <= READ;
                     rd_ready <= 1'b0;
                     beat     <= '0;
                     rd_entry <= E_W'(int'(rd_addr) * N_BEATS);
                  end
               end
            end
            LOAD: begin
               if (wr_fire) begin
                  wr_ptr <= wr_ptr + P_W'(1);
                  if (wr_ptr == P_W'(N_TOTAL - 1)) begin
                     state      <= IDLE;
                     load_ready <= 1'b0;
                     rd_ready   <= 1'b1;
                     loaded     <= 1'b1;
                     load_fin   <= 1'b1;
                  end
               end
            end
            READ: begin
               row_buf  <= next_row;
               beat     <= beat + B_W'(1);
               rd_entry <= rd_entry + E_W'(1);
               if (beat == B_W'(N_BEATS - 1)) begin
                  beat       <= '0;
                  rd_valid   <= 1'b1;
                  rd_err     <= 1'b0;
                  rd_weights <= next_row;
                  state      <= IDLE;
                  rd_ready   <= 1'b1;
               end
            end
            default: begin
               state      <= IDLE;
               rd_ready   <= 1'b0;
               load_ready <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_weight_row_loader.sv
// Self-checking bench for weight_row_loader in a 4x8 matrix, 4-lane configuration.
// Latency: checks row, error and load_done timing in cycles against the accept/start edge.
// Backpressure: drives load_valid throttling and held rd_req to exercise both handshakes.
module tb_weight_row_loader;

   localparam int DW    = 32;
   localparam int IN    = 4;
   localparam int OUT   = 8;
   localparam int LANES = 4;
   localparam int AW    = 8;
   localparam int TOT   = IN * OUT;
   localparam int BEATS = OUT / LANES;
   localparam int RW    = DW * OUT;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          load_start;
   logic          load_valid;
   logic [DW-1:0] load_data;
   logic          load_ready;
   logic          load_done;
   logic          rd_req;
   logic [AW-1:0] rd_addr;
   logic          rd_ready;
   logic          rd_valid;
   logic          rd_err;
   logic [RW-1:0] rd_weights;

   typedef struct {
      logic          err;
      logic [RW-1:0] w;
      int            lat;
   } exp_t;

   exp_t          sb [$];
   logic [DW-1:0] mem_model [TOT];
   bit            loaded_model = 1'b0;
   int            checks   = 0;
   int            failures = 0;

   always #5 clk = ~clk;

   weight_row_loader #(
      .DATA_WIDTH   (DW),
      .INPUT_NODES  (IN),
      .OUTPUT_NODES (OUT),
      .READ_LANES   (LANES),
      .ADDR_WIDTH   (AW)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_start (load_start),
      .load_valid (load_valid),
      .load_data  (load_data),
      .load_ready (load_ready),
      .load_done  (load_done),
      .rd_req     (rd_req),
      .rd_addr    (rd_addr),
      .rd_ready   (rd_ready),
      .rd_valid   (rd_valid),
      .rd_err     (rd_err),
      .rd_weights (rd_weights)
   );

   function automatic exp_t model_row(input logic [AW-1:0] addr);
      exp_t e;
      e.err = !loaded_model || (int'(addr) >= IN);
      e.w   = '0;
      e.lat = e.err ? 1 : BEATS;
      if (!e.err) begin
         for (int j = 0; j < OUT; j++) begin
            e.w[(OUT - 1 - j) * DW +: DW] = mem_model[int'(addr) * OUT + j];
         end
      end
      return e;
   endfunction

   // Full matrix load starting at the current negedge; returns load_done latency and ready drops
   task automatic do_load(input bit throttle, input logic [DW-1:0] base,
                          output int done_lat, output int drops);
      int idx;
      int n;
      bit acc;
      idx = 0;
      n = 0;
      done_lat = -1;
      drops = 0;
      @(negedge clk);
      load_start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      load_start = 1'b0;
      while (n < 200 && done_lat < 0) begin
         if (load_done) begin
            done_lat = n;
         end else begin
            if (idx < TOT && !load_ready) drops++;
            load_valid = (idx < TOT) && (!throttle || (n % 2 == 0));
            load_data  = load_valid ? base + idx : 32'hDEAD_0000 + n;
            acc = load_valid && load_ready;
            @(posedge clk);
            n++;
            if (acc) begin
               mem_model[idx] = base + idx;
               idx++;
            end
            @(negedge clk);
         end
      end
      load_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (load_done !== 1'b0) begin
         failures++;
         $display("FAIL load_done_pulse: got %b expected 0 one cycle after the pulse", load_done);
      end
   endtask

   // Single read: accept, then compare the scoreboard head with the response and its latency
   task automatic check_read(input logic [AW-1:0] addr, input string name);
      exp_t e;
      int n;
      bit seen;
      @(negedge clk);
      rd_req  = 1'b1;
      rd_addr = addr;
      checks++;
      if (rd_ready !== 1'b1) begin
         failures++;
         $display("FAIL %s_rdy: rd_ready got %b expected 1", name, rd_ready);
      end
      @(posedge clk);
      sb.push_back(model_row(addr));
      @(negedge clk);
      rd_req = 1'b0;
      n = 0;
      seen = 1'b0;
      while (n < 10 && !seen) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         if (rd_valid) seen = 1'b1;
      end
      checks++;
      if (!seen) begin
         failures++;
         $display("FAIL %s_timeout: no rd_valid within %0d cycles", name, n);
         sb.delete();
      end else begin
         e = sb.pop_front();
         if (n != e.lat) begin
            failures++;
            $display("FAIL %s_lat: got %0d cycles expected %0d", name, n, e.lat);
         end
         checks++;
         if (rd_err !== e.err) begin
            failures++;
            $display("FAIL %s_err: got %b expected %b", name, rd_err, e.err);
         end
         checks++;
         if (rd_weights !== e.w) begin
            failures++;
            $display("FAIL %s_row: got %h expected %h", name, rd_weights, e.w);
         end
         @(posedge clk);
         @(negedge clk);
         checks++;
         if (rd_valid !== 1'b0 || rd_weights !== e.w) begin
            failures++;
            $display("FAIL %s_hold: rd_valid %b row %h, expected 0 and row %h", name, rd_valid, rd_weights, e.w);
         end
      end
   endtask

   task automatic check_reset_outputs(input string name);
      checks++;
      if ({load_ready, load_done, rd_ready, rd_valid, rd_err} !== 5'b0 || rd_weights !== '0) begin
         failures++;
         $display("FAIL %s: ld_rdy %b ld_done %b rd_rdy %b rd_vld %b rd_err %b row %h, expected all 0",
                  name, load_ready, load_done, rd_ready, rd_valid, rd_err, rd_weights);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      load_start = 1'b0;
      load_valid = 1'b0;
      load_data  = '0;
      rd_req     = 1'b0;
      rd_addr    = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("reset_values");
      rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (rd_ready !== 1'b1 || load_ready !== 1'b0) begin
         failures++;
         $display("FAIL reset_idle: rd_ready %b load_ready %b, expected 1 and 0", rd_ready, load_ready);
      end
   endtask

   task automatic test_read_unloaded();
      check_read(8'd1, "unloaded_read");
   endtask

   task automatic test_full_load();
      int lat;
      int drops;
      do_load(1'b0, 32'h0, lat, drops);
      loaded_model = (lat >= 0);
      checks++;
      if (lat != TOT + 1) begin
         failures++;
         $display("FAIL full_load_lat: load_done after %0d cycles expected %0d", lat, TOT + 1);
      end
      checks++;
      if (drops != 0) begin
         failures++;
         $display("FAIL full_load_ready: load_ready low %0d times expected 0", drops);
      end
      check_read(8'd2, "row2");
      checks++;
      if (rd_weights[255:224] !== 32'h10 || rd_weights[31:0] !== 32'h17) begin
         failures++;
         $display("FAIL row2_ends: got %h/%h expected 10/17", rd_weights[255:224], rd_weights[31:0]);
      end
   endtask

   task automatic test_out_of_range();
      check_read(8'd4, "oor_read");
      check_read(8'd0, "row0_after_oor");
      checks++;
      if (rd_weights[255:224] !== 32'h0 || rd_weights[31:0] !== 32'h7) begin
         failures++;
         $display("FAIL row0_ends: got %h/%h expected 0/7", rd_weights[255:224], rd_weights[31:0]);
      end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      int n;
      int acc_edge;
      int v1;
      int v2;
      bit take;
      @(negedge clk);
      rd_req  = 1'b1;
      rd_addr = 8'd3;
      @(posedge clk);
      sb.push_back(model_row(8'd3));
      n = 0;
      acc_edge = -1;
      v1 = -1;
      v2 = -1;
      @(negedge clk);
      rd_addr = 8'd0;
      while (n < 12 && v2 < 0) begin
         if (rd_valid) begin
            checks++;
            if (sb.size() == 0) begin
               failures++;
               $display("FAIL b2b_extra: rd_valid at cycle %0d with nothing expected", n);
            end else begin
               e = sb.pop_front();
               if (rd_err !== e.err || rd_weights !== e.w) begin
                  failures++;
                  $display("FAIL b2b_row: got err %b row %h expected err %b row %h", rd_err, rd_weights, e.err, e.w);
               end
            end
            if (v1 < 0) v1 = n;
            else v2 = n;
         end
         take = (acc_edge < 0) && rd_ready && rd_req;
         @(posedge clk);
         n++;
         if (take) begin
            acc_edge = n;
            sb.push_back(model_row(8'd0));
         end
         @(negedge clk);
         if (take) rd_req = 1'b0;
      end
      rd_req = 1'b0;
      checks++;
      if (v1 != 2 || acc_edge != 3 || v2 != 5) begin
         failures++;
         $display("FAIL b2b_timing: valid1 %0d accept2 %0d valid2 %0d expected 2 3 5", v1, acc_edge, v2);
      end
      sb.delete();
   endtask

   task automatic test_throttled_load();
      int lat;
      int drops;
      do_load(1'b1, 32'h100, lat, drops);
      loaded_model = (lat >= 0);
      checks++;
      if (lat != 2 * TOT) begin
         failures++;
         $display("FAIL throttle_lat: load_done after %0d cycles expected %0d", lat, 2 * TOT);
      end
      checks++;
      if (drops != 0) begin
         failures++;
         $display("FAIL throttle_ready: load_ready low %0d times expected 0", drops);
      end
      for (int r = 0; r < IN; r++) begin
         check_read(AW'(r), "throttle_row");
      end
   endtask

   task automatic test_contention_reset();
      int stray;
      @(negedge clk);
      load_start = 1'b1;
      rd_req     = 1'b1;
      rd_addr    = 8'd0;
      @(posedge clk);
      @(negedge clk);
      load_start = 1'b0;
      rd_req     = 1'b0;
      checks++;
      if (load_ready !== 1'b1 || rd_ready !== 1'b0) begin
         failures++;
         $display("FAIL contention_state: load_ready %b rd_ready %b expected 1 and 0", load_ready, rd_ready);
      end
      stray = 0;
      for (int i = 0; i < 10; i++) begin
         if (rd_valid || load_done) stray++;
         load_valid = 1'b1;
         load_data  = i;
         rd_req     = (i == 4);
         load_start = (i == 4);
         rd_addr    = 8'd1;
         @(posedge clk);
         @(negedge clk);
      end
      if (rd_valid || load_done) stray++;
      rd_req     = 1'b0;
      load_start = 1'b0;
      checks++;
      if (stray != 0) begin
         failures++;
         $display("FAIL contention_stray: %0d unexpected rd_valid/load_done cycles expected 0", stray);
      end
      rst_n     = 1'b0;
      load_data = 32'd10;
      @(posedge clk);
      @(negedge clk);
      check_reset_outputs("reset_mid_load");
      rst_n = 1'b1;
      load_valid = 1'b0;
      loaded_model = 1'b0;
      check_read(8'd0, "read_after_aborted_load");
   endtask

   task automatic test_reset_mid_read();
      int lat;
      int drops;
      int stray;
      do_load(1'b0, 32'h0, lat, drops);
      loaded_model = (lat >= 0);
      @(negedge clk);
      rd_req  = 1'b1;
      rd_addr = 8'd1;
      @(posedge clk);
      @(negedge clk);
      rd_req = 1'b0;
      rst_n  = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check_reset_outputs("reset_mid_read");
      rst_n = 1'b1;
      stray = 0;
      for (int i = 0; i < 6; i++) begin
         if (rd_valid) stray++;
         @(posedge clk);
         @(negedge clk);
      end
      checks++;
      if (stray != 0) begin
         failures++;
         $display("FAIL reset_read_stray: %0d rd_valid cycles expected 0", stray);
      end
      loaded_model = 1'b0;
      check_read(8'd1, "read_after_read_reset");
   endtask

   initial begin
      test_reset();
      test_read_unloaded();
      test_full_load();
      test_out_of_range();
      test_back_to_back();
      test_throttled_load();
      test_contention_reset();
      test_reset_mid_read();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/weight_row_loader.md
# weight_row_loader

Parametrised, loadable successor to the fixed-content fully-connected weight memories.
- Holds an INPUT_NODES × OUTPUT_NODES weight matrix, written word-serially over a load stream.
- On request, returns the full row of OUTPUT_NODES weights for one input node, gathered over several beats of READ_LANES words each.
- Uses a valid/ready handshake and flags out-of-range and not-yet-loaded reads.
- Sits between the weight-load DMA and the dense-layer MAC array.

## Interface
- DATA_WIDTH, 32, bits per weight word
- INPUT_NODES, 100, rows (input neurons)
- OUTPUT_NODES, 32, weights per row; must be a multiple of READ_LANES
- READ_LANES, 8, words fetched per read beat
- ADDR_WIDTH, 8, width of rd_addr

- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- load_start  in  1  begin full-matrix reload (sampled in IDLE only)
- load_valid  in  1  load_data valid
- load_data  in  DATA_WIDTH  next weight word, row-major (row r, node j at index r*OUTPUT_NODES+j)
- load_ready  out  1  high in LOAD state only
- load_done  out  1  one-cycle pulse after last word written
- rd_req  in  1  read request
- rd_addr  in  ADDR_WIDTH  row index, sampled on accept
- rd_ready  out  1  high in IDLE only
- rd_valid  out  1  one-cycle pulse, row result available
- rd_err  out  1  qualifies rd_valid: address ≥ INPUT_NODES, or matrix not loaded
- rd_weights  out  DATA_WIDTH*OUTPUT_NODES  row; node j at [(OUTPUT_NODES-1-j)*DATA_WIDTH +: DATA_WIDTH]

## Operation
- States: IDLE, LOAD, READ.
- `loaded` flag: cleared by reset and on entering LOAD; set on load completion.
- IDLE transitions:
  - load_start → LOAD, write pointer = 0.
  - Otherwise, rd_req (accept, because rd_ready=1) → READ, or error response.
  - load_start and rd_req in the same cycle: load wins; read not accepted.
- LOAD:
  - Each load_valid & load_ready cycle writes one word at the pointer, then pointer+1.
  - Write of word TOTAL-1 (TOTAL = INPUT_NODES*OUTPUT_NODES): load_done pulses next cycle, loaded=1, → IDLE.
  - load_start and rd_req are ignored in LOAD.
- Read accept with rd_addr ≥ INPUT_NODES, or !loaded:
  - No READ state entered.
  - Next cycle: rd_valid=1, rd_err=1, rd_weights=0.
- Valid read:
  - BEATS = OUTPUT_NODES/READ_LANES beats.
  - Beat b writes nodes b*READ_LANES … b*READ_LANES+READ_LANES-1 into rd_weights.
  - After the final beat: rd_valid=1, rd_err=0, → IDLE.
- Output holding: rd_weights holds its value until the next read completes. It is not cleared when rd_valid drops.
- Partial loads: memory contents are undefined until the first complete load. A load aborted by reset leaves loaded=0.

## Timing
- Reset values: load_ready=0, load_done=0, rd_ready=0 for the reset cycle then 1 (IDLE), rd_valid=0, rd_err=0, rd_weights=0, state IDLE, loaded=0. Memory array is not reset.
- Valid read latency: accept edge E → rd_valid high in the cycle after edge E+BEATS (BEATS cycles). Next accept possible in that same rd_valid cycle.
- Error read latency: rd_valid high in the cycle after the accept edge.
- Load throughput: one word per cycle. With load_valid held high, load_done rises TOTAL+1 cycles after the load_start edge.
- Reset asserted mid-LOAD or mid-READ:
  - Next edge → IDLE, loaded=0, all outputs at reset values.
  - An in-flight read produces no rd_valid.

## Structure
- Package weight_mem_pkg holds:
  - State enum {IDLE, LOAD, READ}.
  - Localparams TOTAL and BEATS.
  - Pointer widths via $clog2(TOTAL) and $clog2(BEATS).
- Sub-module weight_lane_bank: one per lane, READ_LANES instances.
  - Simple 1-write/1-read array of depth TOTAL/READ_LANES.
  - Word index k is stored in bank k % READ_LANES at entry k / READ_LANES.
  - All banks are read in parallel each beat.
- Top level contains the FSM, write pointer, beat counter, row assembly register and error decode.

## Test plan
Configuration for all scenarios: INPUT_NODES=4, OUTPUT_NODES=8, READ_LANES=4, DATA_WIDTH=32, load_data = word index.
- Read before any load: rd_addr=1 → rd_valid and rd_err pulse 1 cycle after accept, rd_weights=0.
- Full load:
  - 32 back-to-back words → load_done pulses once, 33 cycles after the load_start edge.
  - Then read rd_addr=2 → rd_valid 2 cycles after accept, rd_weights[255:224]=0x10, rd_weights[31:0]=0x17, rd_err=0.
- Out-of-range read: rd_addr=4 after load → rd_err=1, rd_weights=0. A following read of addr 0 returns 0x00…0x07.
- Throttled load: load_valid toggling 1/0 → load_ready stays high, only valid words advance the pointer, final contents are correct.
- Contention and reset:
  - load_start and rd_req in the same IDLE cycle → LOAD entered, no rd_valid.
  - Reset at load word 10 → loaded=0, and a subsequent read returns rd_err=1.
- Back-to-back reads: rd_req held with addr 3 then addr 0 → second accept in the first rd_valid cycle. Rows 0x18…0x1F then 0x00…0x07.
